mul_div_unit: RTL and testbench

Iterative RV32M multiply/divide unit for the single-cycle RISC-V core.
- Consumes the two operands read from the register file (`readData1`/`readData2`) plus the destination index.
- Computes one of the eight M-extension operations over multiple cycles while asserting `busy` so the control path stalls.
- Produces a one-cycle write-back request (`regWrite`, `writeReg`, `writeData`) that drives the register file's write port directly.

---
 rtl/mul_div_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative RV32M multiply/divide unit. Converts the operands to
//               magnitudes, runs an unsigned shift-add multiplier or restoring
//               divider for one bit per cycle, then applies the result sign.
//               It asserts busy while working and issues a one-cycle
//               register-file write request when the result is ready.
//               Ports:
//                 clk, reset          clock, synchronous active-high reset
//                 start, funct3       request and operation select
//                 rs1Data, rs2Data    operand A, operand B
//                 rd                  destination register index
//                 busy, done          in-progress flag, one-cycle completion
//                 regWrite, writeReg,
//                 writeData           register-file write port request
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_unit #(
    parameter int WORDSIZE = 32,
    parameter int ADDRSIZE = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [2:0]          funct3,
    input  logic [WORDSIZE-1:0] rs1Data,
    input  logic [WORDSIZE-1:0] rs2Data,
    input  logic [ADDRSIZE-1:0] rd,
    output logic                busy,
    output logic                done,
    output logic                regWrite,
    output logic [ADDRSIZE-1:0] writeReg,
    output logic [WORDSIZE-1:0] writeData
);

    // Counter must be able to hold the value WORDSIZE (finalise step).
    localparam int c_CNT_W = $clog2(WORDSIZE + 1);
    localparam logic [c_CNT_W-1:0] c_last_iter = c_CNT_W'(WORDSIZE);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [WORDSIZE-1:0] c_most_neg = {1'b1, {(WORDSIZE-1){1'b0}}};
    localparam logic [WORDSIZE-1:0] c_all_ones = {WORDSIZE{1'b1}};
    localparam logic [WORDSIZE-1:0] c_zero     = {WORDSIZE{1'b0}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]            r_state;
    logic [c_CNT_W-1:0]    r_count;
    // Multiply: {product high, multiplier / product low}.
    // Divide:   {partial remainder, dividend / quotient}.
    // Special cases park their ready-made result in the low half.
    logic [2*WORDSIZE-1:0] r_acc;
    // Multiplicand magnitude (multiply) or divisor magnitude (divide).
    logic [WORDSIZE-1:0]   r_operand;
    logic [2:0]            r_funct3;
    logic                  r_negate;
    logic                  r_special;
    logic [ADDRSIZE-1:0]   r_write_reg;
    logic [WORDSIZE-1:0]   r_write_data;

    // ------------------------------------------------------------------
    // Accept-time decode, evaluated on the live inputs
    // ------------------------------------------------------------------
    logic                w_is_div;
    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [WORDSIZE-1:0] w_mag_a;
    logic [WORDSIZE-1:0] w_mag_b;
    logic                w_div_zero;
    logic                w_overflow;
    logic                w_special;
    logic [WORDSIZE-1:0] w_special_result;
    logic                w_negate;

    assign w_is_div   = funct3[2];
    // Multiply group: A signed except MULHU; B signed only for MUL/MULH.
    // Divide group: the even encodings (DIV/REM) are signed.
    assign w_a_signed = w_is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign w_b_signed = w_is_div ? ~funct3[0] : ~funct3[1];
    assign w_a_neg    = w_a_signed & rs1Data[WORDSIZE-1];
    assign w_b_neg    = w_b_signed & rs2Data[WORDSIZE-1];
    assign w_mag_a    = w_a_neg ? (c_zero - rs1Data) : rs1Data;
    assign w_mag_b    = w_b_neg ? (c_zero - rs2Data) : rs2Data;

    assign w_div_zero = w_is_div & (rs2Data == c_zero);
    assign w_overflow = w_is_div & ~funct3[0] & (rs1Data == c_most_neg) &
                        (rs2Data == c_all_ones);
    assign w_special  = w_div_zero | w_overflow;

    // funct3[1] distinguishes remainder (REM/REMU) from quotient (DIV/DIVU).
    always_comb begin
        w_special_result = c_zero;
        if (w_div_zero) begin
            w_special_result = funct3[1] ? rs1Data : c_all_ones;
        end else if (w_overflow) begin
            w_special_result = funct3[1] ? c_zero : rs1Data;
        end
    end

    // Remainder takes the dividend's sign; product and quotient the XOR.
    assign w_negate = (w_is_div & funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

    // ------------------------------------------------------------------
    // One iteration of the unsigned cores
    // ------------------------------------------------------------------
    logic [WORDSIZE:0]     w_mul_sum;
    logic [WORDSIZE:0]     w_mul_upper;
    logic [2*WORDSIZE-1:0] w_mul_next;
    logic [WORDSIZE:0]     w_div_shift;
    logic                  w_div_ge;
    logic [WORDSIZE-1:0]   w_div_rem;
    logic [2*WORDSIZE-1:0] w_div_next;
    logic [2*WORDSIZE-1:0] w_acc_step;

    // Shift-add: add the multiplicand to the high half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    assign w_mul_sum   = {1'b0, r_acc[2*WORDSIZE-1:WORDSIZE]} + {1'b0, r_operand};
    assign w_mul_upper = r_acc[0] ? w_mul_sum : {1'b0, r_acc[2*WORDSIZE-1:WORDSIZE]};
    assign w_mul_next  = {w_mul_upper, r_acc[WORDSIZE-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder and
    // subtract the divisor if it fits; the fit bit becomes a quotient bit.
    assign w_div_shift = r_acc[2*WORDSIZE-1:WORDSIZE-1];
    assign w_div_ge    = (w_div_shift >= {1'b0, r_operand});
    assign w_div_rem   = w_div_ge ? (w_div_shift[WORDSIZE-1:0] - r_operand)
                                  : w_div_shift[WORDSIZE-1:0];
    assign w_div_next  = {w_div_rem, r_acc[WORDSIZE-2:0], w_div_ge};

    assign w_acc_step  = r_funct3[2] ? w_div_next : w_mul_next;

    // ------------------------------------------------------------------
    // Sign correction and result selection
    // ------------------------------------------------------------------
    logic [2*WORDSIZE-1:0] w_prod;
    logic [WORDSIZE-1:0]   w_mul_result;
    logic [WORDSIZE-1:0]   w_quo;
    logic [WORDSIZE-1:0]   w_rem;
    logic [WORDSIZE-1:0]   w_div_result;
    logic [WORDSIZE-1:0]   w_final;

    assign w_prod       = r_negate ? ({(2*WORDSIZE){1'b0}} - r_acc) : r_acc;
    assign w_mul_result = (r_funct3[1:0] == 2'b00) ? w_prod[WORDSIZE-1:0]
                                                   : w_prod[2*WORDSIZE-1:WORDSIZE];
    assign w_quo        = r_negate ? (c_zero - r_acc[WORDSIZE-1:0]) : r_acc[WORDSIZE-1:0];
    assign w_rem        = r_negate ? (c_zero - r_acc[2*WORDSIZE-1:WORDSIZE])
                                   : r_acc[2*WORDSIZE-1:WORDSIZE];
    assign w_div_result = r_funct3[1] ? w_rem : w_quo;
    assign w_final      = r_special   ? r_acc[WORDSIZE-1:0] :
                          r_funct3[2] ? w_div_result : w_mul_result;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    // Special cases still spend their first busy cycle in RUN and leave it
    // at once: the result appears one edge after accept, and busy covers
    // the accept cycle so a second start cannot slip in.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_count      <= '0;
            r_acc        <= '0;
            r_operand    <= '0;
            r_funct3     <= '0;
            r_negate     <= 1'b0;
            r_special    <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state     <= c_st_run;
                        r_count     <= '0;
                        r_funct3    <= funct3;
                        r_negate    <= w_negate;
                        r_special   <= w_special;
                        r_write_reg <= rd;
                        if (w_special) begin
                            r_acc     <= {c_zero, w_special_result};
                            r_operand <= c_zero;
                        end else if (w_is_div) begin
                            r_acc     <= {c_zero, w_mag_a};
                            r_operand <= w_mag_b;
                        end else begin
                            r_acc     <= {c_zero, w_mag_b};
                            r_operand <= w_mag_a;
                        end
                    end
                end
                c_st_run: begin
                    // WORDSIZE iterations, then one edge to apply the sign.
                    if (r_special || (r_count == c_last_iter)) begin
                        r_write_data <= w_final;
                        r_state      <= c_st_done;
                    end else begin
                        r_acc   <= w_acc_step;
                        r_count <= r_count + c_CNT_W'(1);
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from registers only)
    // ------------------------------------------------------------------
    assign busy      = (r_state != c_st_idle);
    assign done      = (r_state == c_st_done);
    assign regWrite  = done && (r_write_reg != '0);
    assign writeReg  = r_write_reg;
    assign writeData = r_write_data;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Self-checking bench for mul_div_unit. Stimulus pushes the
//               expected write-back into a queue; a monitor pops and compares
//               whenever done is raised. Random operations are checked
//               against a plain-arithmetic RV32M reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1Data;
    logic [31:0] rs2Data;
    logic [4:0]  rd;
    logic        busy;
    logic        done;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;

    mul_div_unit #(.WORDSIZE(32), .ADDRSIZE(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .funct3   (funct3),
        .rs1Data  (rs1Data),
        .rs2Data  (rs2Data),
        .rd       (rd),
        .busy     (busy),
        .done     (done),
        .regWrite (regWrite),
        .writeReg (writeReg),
        .writeData(writeData)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        int          due;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // RV32M reference from the instruction-set definition.
    function automatic logic [31:0] ref_result(input logic [2:0] f3,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] ss;
        logic signed [63:0] su;
        logic [63:0]        uu;
        int                 sa;
        int                 sb_i;
        logic [31:0]        r;
        ss   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        su   = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
        uu   = {32'b0, a} * {32'b0, b};
        sa   = $signed(a);
        sb_i = $signed(b);
        r    = 32'h0;
        case (f3)
            3'd0: r = uu[31:0];
            3'd1: r = ss[63:32];
            3'd2: r = su[63:32];
            3'd3: r = uu[63:32];
            3'd4: begin
                if (b == 32'h0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = 32'(sa / sb_i);
            end
            3'd5: r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'h0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else r = 32'(sa % sb_i);
            end
            default: r = (b == 32'h0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        return f3[2] && ((b == 32'h0) ||
                         (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Waits for idle, presents one request and (optionally) records the
    // expected write-back with its due cycle.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input logic [31:0] exp_data, input bit track);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        while (busy && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL issue_wait: busy=%0b after %0d cycles, required 0", busy, waited);
        end
        start   = 1'b1;
        funct3  = f3;
        rs1Data = a;
        rs2Data = b;
        rd      = r;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (track) begin
            e.data = exp_data;
            e.rd   = r;
            e.due  = cyc + (is_special(f3, a, b) ? 1 : 33);
            sb.push_back(e);
        end
    endtask

    // Monitor: compares each completion against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got writeData=%h writeReg=%0d, required no completion",
                             writeData, writeReg);
                end else begin
                    e = sb.pop_front();
                    check("writeData", writeData, e.data);
                    check("writeReg", 32'(writeReg), 32'(e.rd));
                    check("regWrite", 32'(regWrite), 32'(e.rd != 5'd0));
                    check("done_cycle", cyc, e.due);
                    check("busy_in_done", 32'(busy), 32'd1);
                end
            end else if (regWrite) begin
                total++;
                bad++;
                $display("FAIL regWrite_outside_done: got regWrite=1, required 0");
            end
        end
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        int          waited;

        reset   = 1'b1;
        start   = 1'b0;
        funct3  = 3'd0;
        rs1Data = 32'h0;
        rs2Data = 32'h0;
        rd      = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_regWrite", 32'(regWrite), 32'd0);
        check("reset_writeReg", 32'(writeReg), 32'd0);
        check("reset_writeData", writeData, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed operations with hand-computed results.
        issue(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b1);
        issue(3'd1, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000, 1'b1);
        issue(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 1'b1);
        issue(3'd2, 32'hFFFF_FFFF,  32'd2,         5'd3,  32'hFFFF_FFFF, 1'b1);
        issue(3'd4, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD, 1'b1);
        issue(3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF, 1'b1);
        issue(3'd5, 32'd100,        32'd7,         5'd7,  32'd14,        1'b1);
        issue(3'd7, 32'd100,        32'd7,         5'd8,  32'd2,         1'b1);
        issue(3'd5, 32'd100,        32'd0,         5'd9,  32'hFFFF_FFFF, 1'b1);
        issue(3'd6, 32'h1234,       32'd0,         5'd10, 32'h1234,      1'b1);
        issue(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1'b1);
        issue(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'h0,         1'b1);

        // New requests while busy must be dropped.
        issue(3'd0, 32'd5, 32'd6, 5'd13, 32'd30, 1'b1);
        repeat (5) begin
            @(negedge clk);
            start   = 1'b1;
            funct3  = 3'd5;
            rs1Data = 32'd1;
            rs2Data = 32'd0;
            rd      = 5'd9;
        end
        @(negedge clk);
        start = 1'b0;

        // rd = 0: done pulses, no register write.
        issue(3'd0, 32'd9, 32'd9, 5'd0, 32'd81, 1'b1);

        // Reset in the middle of RUN, with start held high alongside it.
        issue(3'd0, 32'd11, 32'd13, 5'd4, 32'd0, 1'b0);
        repeat (10) @(negedge clk);
        reset   = 1'b1;
        start   = 1'b1;
        funct3  = 3'd0;
        rs1Data = 32'd3;
        rs2Data = 32'd4;
        rd      = 5'd2;
        @(posedge clk);
        #1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_writeData", writeData, 32'd0);
        check("midreset_regWrite", 32'(regWrite), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("after_reset_idle", 32'(busy), 32'd0);
        issue(3'd0, 32'd3, 32'd4, 5'd14, 32'd12, 1'b1);

        // Randomised operations, biased toward the corner cases.
        for (int i = 0; i < 60; i++) begin
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0: begin a = $urandom; b = 32'h0; end
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                3: begin a = 32'h8000_0000; b = $urandom; end
                default: begin a = $urandom; b = $urandom; end
            endcase
            issue(f3, a, b, 5'($urandom_range(0, 31)), ref_result(f3, a, b), 1'b1);
        end

        waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
